pin_auth_ctrl: RTL and testbench

//  Multi-account PIN authentication controller for the vending/bank front panel.
//  The user selects an account, enters a PIN_LEN-digit PIN on n[3:0], confirming each digit with the

---
 rtl/pin_auth_if.sv | 25 ++
 rtl/pin_auth_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pin_auth_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pin_auth_if.sv
// Front-panel bus of the PIN authentication controller: button/digit/account inputs
// from the panel, seven-segment display and status outputs back to it.
interface pin_auth_if #(
  parameter int AW = 2
);
  logic          next;
  logic [3:0]    n;
  logic [AW-1:0] acc;
  logic          chg;
  logic          logout;
  logic [63:0]   show;
  logic          unlocked;
  logic          locked;
  logic [AW-1:0] cur_acc;

  modport master (
    output next, n, acc, chg, logout,
    input  show, unlocked, locked, cur_acc
  );

  modport slave (
    input  next, n, acc, chg, logout,
    output show, unlocked, locked, cur_acc
  );
endinterface

// File: rtl/pin_auth_ctrl.sv
// Multi-account PIN authentication FSM with try counting, timed lockout, PIN change
// and a directly driven 8-digit active-low seven-segment display.
module pin_auth_ctrl #(
  parameter int          NUM_ACC  = 4,
  parameter int          PIN_LEN  = 3,
  parameter int          MAX_TRY  = 3,
  parameter logic [31:0] LOCK_CYC = 32'd100_000_000,
  parameter logic [23:0] DEF_PIN  = 24'h000123
) (
  input  logic      clk,
  input  logic      rst,
  pin_auth_if.slave bus
);
  localparam int AW = $clog2(NUM_ACC);
  localparam int PW = 4 * PIN_LEN;
  localparam int TW = $clog2(MAX_TRY + 1);
  localparam logic [2:0]    PLEN     = 3'(PIN_LEN);
  localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRY - 1);

  localparam logic [7:0]  SEG_BLANK  = 8'hFF;
  localparam logic [7:0]  SEG_DASH   = 8'hBF;
  localparam logic [7:0]  SEG_P      = 8'h8C;
  localparam logic [31:0] NEWPIN_TAG = 32'hAB86_E3FF;
  localparam logic [63:0] MSG_OK     = 64'hFF92_C1C6_C686_9292;
  localparam logic [63:0] MSG_LOCK   = 64'hC7C0_C689_86A1_FFFF;
  localparam logic [31:0] MSG_FAIL   = 32'h8E88_CFC7;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ENTER, ST_CHECK, ST_FAIL, ST_LOCK, ST_OK, ST_NEWPIN
  } state_t;

  state_t        state_q;
  logic          q1_q, q2_q;
  logic [2:0]    cnt_q;
  logic [TW-1:0] try_q;
  logic [31:0]   timer_q;
  logic [PW-1:0] buf_q;
  logic [AW-1:0] cur_acc_q;
  logic [63:0]   show_q, show_d;
  logic [PW-1:0] pin_q [NUM_ACC];

  logic          nxt_p, digit_ok;
  logic [3:0]    fail_left;
  logic [63:0]   enter_disp, newpin_disp;

  assign nxt_p     = q1_q & ~q2_q;
  assign digit_ok  = nxt_p && (bus.n <= 4'd9);
  assign fail_left = 4'(MAX_TRY) - 4'(try_q);

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Digit 0 is the leftmost position; entered digits only ever appear as dashes.
  for (genvar gi = 0; gi < 8; gi++) begin : g_disp
    assign enter_disp[63-8*gi -: 8] = (3'(gi) < cnt_q) ? SEG_DASH : SEG_BLANK;
    if (gi < 4) begin : g_tag
      assign newpin_disp[63-8*gi -: 8] = NEWPIN_TAG[31-8*gi -: 8];
    end else begin : g_dash
      assign newpin_disp[63-8*gi -: 8] = (3'(gi - 4) < cnt_q) ? SEG_DASH : SEG_BLANK;
    end
  end

  always_comb begin
    show_d = '1;
    case (state_q)
      ST_IDLE:   show_d = {SEG_P, seg_digit(4'(bus.acc)), 48'hFFFF_FFFF_FFFF};
      ST_ENTER,
      ST_CHECK:  show_d = enter_disp;
      ST_FAIL:   show_d = {MSG_FAIL, SEG_BLANK, seg_digit(fail_left), SEG_BLANK, SEG_BLANK};
      ST_LOCK:   show_d = MSG_LOCK;
      ST_OK:     show_d = MSG_OK;
      ST_NEWPIN: show_d = newpin_disp;
      default:   show_d = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      q1_q      <= 1'b0;
      q2_q      <= 1'b0;
      cnt_q     <= '0;
      try_q     <= '0;
      timer_q   <= '0;
      buf_q     <= '0;
      cur_acc_q <= '0;
      show_q    <= '1;
      for (int i = 0; i < NUM_ACC; i++) pin_q[i] <= DEF_PIN[PW-1:0];
    end else begin
      q1_q   <= bus.next;
      q2_q   <= q1_q;
      show_q <= show_d;
      case (state_q)
        ST_IDLE: if (nxt_p) begin
          cur_acc_q <= bus.acc;
          cnt_q     <= '0;
          state_q   <= ST_ENTER;
        end
        ST_ENTER: begin
          if (cnt_q == PLEN) begin
            state_q <= ST_CHECK;
          end else if (digit_ok) begin
            buf_q <= PW'({buf_q, bus.n});
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_CHECK: begin
          if (buf_q == pin_q[cur_acc_q]) begin
            try_q   <= '0;
            state_q <= ST_OK;
          end else if (try_q == TRY_LAST) begin
            try_q   <= '0;
            timer_q <= LOCK_CYC - 32'd1;
            state_q <= ST_LOCK;
          end else begin
            try_q   <= try_q + 1'b1;
            state_q <= ST_FAIL;
          end
        end
        ST_FAIL: if (nxt_p) begin
          cnt_q   <= '0;
          state_q <= ST_ENTER;
        end
        ST_LOCK: begin
          if (timer_q == 32'd0) state_q <= ST_IDLE;
          else                  timer_q <= timer_q - 32'd1;
        end
        ST_OK: begin
          if (bus.logout) begin
            state_q <= ST_IDLE;
          end else if (nxt_p && bus.chg) begin
            cnt_q   <= '0;
            state_q <= ST_NEWPIN;
          end
        end
        ST_NEWPIN: begin
          // Abort leaves the stored PIN untouched; it is only written on completion.
          if (bus.logout) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == PLEN) begin
            pin_q[cur_acc_q] <= buf_q;
            state_q          <= ST_OK;
          end else if (digit_ok) begin
            buf_q <= PW'({buf_q, bus.n});
            cnt_q <= cnt_q + 3'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.show     = show_q;
  assign bus.unlocked = (state_q == ST_OK) || (state_q == ST_NEWPIN);
  assign bus.locked   = (state_q == ST_LOCK);
  assign bus.cur_acc  = cur_acc_q;
endmodule

// File: tb/tb_pin_auth_ctrl.sv
// Directed bench for pin_auth_ctrl: login, failures/lockout, button edge handling,
// PIN change, logout priority and reset recovery.
module tb_pin_auth_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [63:0] SH_BLANK   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SH_OK      = 64'hFF92_C1C6_C686_9292;
  localparam logic [63:0] SH_F2      = 64'h8E88_CFC7_FFA4_FFFF;
  localparam logic [63:0] SH_F1      = 64'h8E88_CFC7_FFF9_FFFF;
  localparam logic [63:0] SH_LOCK    = 64'hC7C0_C689_86A1_FFFF;
  localparam logic [63:0] SH_IDLE0   = 64'h8CC0_FFFF_FFFF_FFFF;
  localparam logic [63:0] SH_IDLE1   = 64'h8CF9_FFFF_FFFF_FFFF;
  localparam logic [63:0] SH_IDLE2   = 64'h8CA4_FFFF_FFFF_FFFF;
  localparam logic [63:0] SH_ENT1    = 64'hBFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SH_ENT2    = 64'hBFBF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SH_NEWPIN0 = 64'hAB86_E3FF_FFFF_FFFF;
  localparam logic [63:0] SH_NEWPIN2 = 64'hAB86_E3FF_BFBF_FFFF;

  pin_auth_if #(.AW(2)) bus ();

  pin_auth_ctrl #(
    .NUM_ACC (4),
    .PIN_LEN (3),
    .MAX_TRY (3),
    .LOCK_CYC(32'd20),
    .DEF_PIN (24'h000123)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic press_btn();
    bus.next = 1'b1;
    tick(1);
    bus.next = 1'b0;
    tick(1);
  endtask

  task automatic press(input logic [3:0] d);
    bus.n = d;
    press_btn();
  endtask

  task automatic enter3(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2);
    press(d0);
    press(d1);
    press(d2);
  endtask

  // OK must be reached within 2 cycles of the last accepted digit
  task automatic wait_unlocked(input string tag);
    int k = 0;
    while (!bus.unlocked && k < 2) begin
      tick(1);
      k++;
    end
    check(tag, 64'(bus.unlocked), 64'd1);
  endtask

  task automatic login(input logic [1:0] a, input logic [3:0] d0, input logic [3:0] d1,
                       input logic [3:0] d2, input string tag);
    bus.acc = a;
    press_btn();
    enter3(d0, d1, d2);
    wait_unlocked(tag);
  endtask

  task automatic do_logout();
    bus.logout = 1'b1;
    tick(2);
    bus.logout = 1'b0;
    tick(1);
  endtask

  initial begin
    int lock_cnt;
    logic [63:0] lock_show;
    bus.next = 1'b0; bus.n = 4'd0; bus.acc = 2'd0; bus.chg = 1'b0; bus.logout = 1'b0;

    // Reset state
    tick(3);
    check("rst_show", bus.show, SH_BLANK);
    check("rst_unlocked", 64'(bus.unlocked), 64'd0);
    check("rst_locked", 64'(bus.locked), 64'd0);
    check("rst_cur_acc", 64'(bus.cur_acc), 64'd0);
    rst = 1'b1;

    // 1: default PIN on account 2; acc changes during entry are ignored
    bus.acc = 2'd2;
    tick(2);
    check("idle_show_acc2", bus.show, SH_IDLE2);
    press_btn();
    check("cur_acc_latched", 64'(bus.cur_acc), 64'd2);
    press(4'd1);
    bus.acc = 2'd3;
    press(4'd2);
    press(4'd3);
    wait_unlocked("t1_unlocked");
    tick(1);
    check("t1_show_ok", bus.show, SH_OK);
    check("t1_cur_acc_kept", 64'(bus.cur_acc), 64'd2);
    do_logout();
    check("t1_logout", 64'(bus.unlocked), 64'd0);

    // 2: three wrong PINs on account 0 -> FAIL 2, FAIL 1, lockout of 20 cycles
    bus.acc = 2'd0;
    press_btn();
    enter3(4'd4, 4'd5, 4'd6);
    tick(3);
    check("t2_fail_show_2", bus.show, SH_F2);
    check("t2_fail_unlocked", 64'(bus.unlocked), 64'd0);
    press_btn();
    enter3(4'd4, 4'd5, 4'd6);
    tick(3);
    check("t2_fail_show_1", bus.show, SH_F1);
    press_btn();
    enter3(4'd4, 4'd5, 4'd6);
    lock_cnt = 0;
    lock_show = '0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (bus.locked) begin
        lock_cnt++;
        if (lock_cnt == 5) lock_show = bus.show;
      end
    end
    check("t2_lock_cycles", 64'(lock_cnt), 64'd20);
    check("t2_lock_show", lock_show, SH_LOCK);
    check("t2_after_lock_show", bus.show, SH_IDLE0);
    // try counter restarts after lockout
    press_btn();
    enter3(4'd4, 4'd5, 4'd6);
    tick(3);
    check("t2_try_cleared", bus.show, SH_F2);
    press_btn();
    enter3(4'd1, 4'd2, 4'd3);
    wait_unlocked("t2_recover_ok");
    do_logout();

    // 3: held button gives one digit; non-BCD digit ignored
    bus.acc = 2'd1;
    press_btn();
    bus.n = 4'd1;
    bus.next = 1'b1;
    tick(50);
    bus.next = 1'b0;
    tick(2);
    check("t3_hold_one_digit", bus.show, SH_ENT1);
    press(4'hC);
    tick(1);
    check("t3_nonbcd_ignored", bus.show, SH_ENT1);
    press(4'd2);
    tick(1);
    check("t3_two_dashes", bus.show, SH_ENT2);
    press(4'd3);
    wait_unlocked("t3_unlocked");
    do_logout();

    // 4: change account 3 PIN to 987
    login(2'd3, 4'd1, 4'd2, 4'd3, "t4_login_old");
    bus.chg = 1'b1;
    press_btn();
    bus.chg = 1'b0;
    tick(1);
    check("t4_newpin_show", bus.show, SH_NEWPIN0);
    press(4'd9);
    press(4'd8);
    tick(1);
    check("t4_newpin_dashes", bus.show, SH_NEWPIN2);
    press(4'd7);
    tick(2);
    check("t4_back_to_ok", bus.show, SH_OK);
    do_logout();
    login(2'd3, 4'd9, 4'd8, 4'd7, "t4_login_new");
    do_logout();
    bus.acc = 2'd3;
    press_btn();
    enter3(4'd1, 4'd2, 4'd3);
    tick(3);
    check("t4_old_pin_rejected", bus.show, SH_F2);
    press_btn();
    enter3(4'd9, 4'd8, 4'd7);
    wait_unlocked("t4_new_pin_again");
    do_logout();
    login(2'd1, 4'd1, 4'd2, 4'd3, "t4_other_acc");
    do_logout();

    // 5: logout beats a simultaneous change request; aborted change keeps PIN
    login(2'd1, 4'd1, 4'd2, 4'd3, "t5_login");
    bus.chg = 1'b1;
    bus.next = 1'b1;
    tick(1);
    bus.logout = 1'b1;
    tick(1);
    bus.next = 1'b0;
    bus.logout = 1'b0;
    bus.chg = 1'b0;
    tick(2);
    check("t5_logout_wins", 64'(bus.unlocked), 64'd0);
    check("t5_idle_show", bus.show, SH_IDLE1);
    login(2'd1, 4'd1, 4'd2, 4'd3, "t5_login2");
    bus.chg = 1'b1;
    press_btn();
    bus.chg = 1'b0;
    press(4'd5);
    press(4'd5);
    do_logout();
    check("t5_abort_logout", 64'(bus.unlocked), 64'd0);
    login(2'd1, 4'd1, 4'd2, 4'd3, "t5_pin_unchanged");
    do_logout();

    // 6: reset during lockout after a PIN change restores everything
    login(2'd2, 4'd1, 4'd2, 4'd3, "t6_login");
    bus.chg = 1'b1;
    press_btn();
    bus.chg = 1'b0;
    enter3(4'd4, 4'd4, 4'd4);
    tick(2);
    do_logout();
    bus.acc = 2'd0;
    for (int i = 0; i < 3; i++) begin
      press_btn();
      enter3(4'd7, 4'd7, 4'd7);
      tick(3);
    end
    check("t6_locked", 64'(bus.locked), 64'd1);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check("t6_rst_locked", 64'(bus.locked), 64'd0);
    check("t6_rst_show", bus.show, SH_BLANK);
    check("t6_rst_cur_acc", 64'(bus.cur_acc), 64'd0);
    login(2'd2, 4'd1, 4'd2, 4'd3, "t6_pin_restored");
    do_logout();
    login(2'd0, 4'd1, 4'd2, 4'd3, "t6_acc0_ok");
    do_logout();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
